// File: rtl/fifo_word_unpacker_pkg.sv
// Shared definitions for the FIFO word unpacker.
//   - Default word/beat/counter widths.
//   - FSM state encoding (IDLE/REQ/CAPT/SEND).
//   - Helpers that derive the beat count and byte-index width.
package fifo_word_unpacker_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAPT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  // Number of beats carried by one FIFO word.
  function automatic int nbytes(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  // Width of a byte index; at least one bit so a 1-beat word still has a register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// Bus bundle between the unpacker and its neighbours.
//   FIFO read side : fifo_empty, fifo_data (into unpacker), fifo_rd (from unpacker)
//   Byte stream    : tx_data, tx_valid, tx_last (from unpacker), tx_ready (into unpacker)
// Modports:
//   master - the unpacker
//   slave  - the FIFO read port plus the downstream transmitter
interface fifo_word_unpacker_if
  import fifo_word_unpacker_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BYTE_W = DEF_BYTE_W
) ();

  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_rd;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_rd, tx_data, tx_valid, tx_last
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_rd, tx_data, tx_valid, tx_last
  );

endinterface

// File: rtl/fifo_word_unpacker_byte_shift.sv
// Word register, byte index and registered beat selector.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   load_i    : capture word_i and present its first beat
//   advance_i : current beat accepted; step to the next beat (index wraps after the last)
//   word_i    : popped FIFO word
//   beat_o    : registered beat data
//   last_o    : registered flag, high while beat_o is the final beat of the word
// The caller gates load_i/advance_i with the module enable, so all registers
// simply hold when neither strobe is active.
module fifo_word_unpacker_byte_shift
  import fifo_word_unpacker_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [BYTE_W-1:0] beat_o,
  output logic              last_o
);

  localparam int                NBYTES   = nbytes(WORD_W, BYTE_W);
  localparam int                IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_next;
  logic [BYTE_W-1:0] beat_q, beat_d;
  logic              last_q, last_d;

  // Beat k of word w in transmit order.
  function automatic logic [BYTE_W-1:0] pick(input logic [WORD_W-1:0] w,
                                             input logic [IDX_W-1:0]  k);
    int pos;
    pos = LSB_FIRST ? int'(k) : (NBYTES - 1 - int'(k));
    return BYTE_W'(w >> (pos * BYTE_W));
  endfunction

  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  // NOTE: every always_comb output gets a hold default first, so no path can infer a latch.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    beat_d = beat_q;
    last_d = last_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
      beat_d = pick(word_i, '0);
      last_d = (NBYTES == 1);
    end else if (advance_i) begin
      idx_d = idx_next;
      // On the final beat the output register keeps its value; tx_valid drops instead.
      if (idx_q != LAST_IDX) begin
        beat_d = pick(word_q, idx_next);
        last_d = (idx_next == LAST_IDX);
      end
    end
  end

  // NOTE: the word register is reset along with the control state so a discarded
  // partial word can never leak out after reset; it is one word wide, not a memory array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
      beat_q <= '0;
      last_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      beat_q <= beat_d;
      last_q <= last_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = last_q;

endmodule

// File: rtl/fifo_word_unpacker.sv
// Consumer-side engine for a word FIFO: pops one word at a time and streams it
// out as NBYTES valid/ready beats.
//   clk_i        : clock, all logic on posedge
//   rst_i        : synchronous active-high reset (wins over en_i)
//   en_i         : enable, shared with the FIFO; when low everything holds
//   bus          : master side of the FIFO read port and the byte stream
//   busy_o       : high whenever the FSM is outside IDLE
//   words_sent_o : words whose last beat was accepted, wraps silently
module fifo_word_unpacker
  import fifo_word_unpacker_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int BYTE_W    = DEF_BYTE_W,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  fifo_word_unpacker_if.master bus,
  output logic                busy_o,
  output logic [CNT_W-1:0]    words_sent_o
);

  state_e            state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              load, advance, beat_fire;
  logic [BYTE_W-1:0] beat;
  logic              beat_last;

  assign beat_fire = en_i && tx_valid_q && bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    words_d    = words_q;
    load       = 1'b0;
    advance    = 1'b0;
    if (en_i) begin
      unique case (state_q)
        ST_IDLE: if (!bus.fifo_empty) state_d = ST_REQ;
        ST_REQ:  state_d = ST_CAPT;
        // fifo_data is registered in the FIFO, so the popped word is only valid here.
        ST_CAPT: begin
          load       = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
        ST_SEND: begin
          if (beat_fire) begin
            advance = 1'b1;
            if (beat_last) begin
              words_d    = words_q + CNT_W'(1);
              tx_valid_d = 1'b0;
              state_d    = bus.fifo_empty ? ST_IDLE : ST_REQ;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      words_q    <= words_d;
    end
  end

  fifo_word_unpacker_byte_shift #(
    .WORD_W    (WORD_W),
    .BYTE_W    (BYTE_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_byte_shift (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .advance_i (advance),
    .word_i    (bus.fifo_data),
    .beat_o    (beat),
    .last_o    (beat_last)
  );

  // One RD pulse per REQ visit; gated by en_i (the FIFO would not sample it anyway)
  // and by rst_i so a reset cycle never pops a word that is about to be discarded.
  assign bus.fifo_rd  = (state_q == ST_REQ) && en_i && !rst_i;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = beat;
  assign bus.tx_last  = beat_last;
  assign busy_o       = (state_q != ST_IDLE);
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Testbench: an MSB-first and an LSB-first unpacker share one behavioural FIFO and
// one ready signal. Every pop pushes the expected beats for both builds into
// scoreboard queues; a negedge monitor pops and compares on each handshake and
// also checks stream stability, read legality and the word counter.
module tb_fifo_word_unpacker;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk, rst, en, ready;
  logic        busy_m, busy_l;
  logic [15:0] ws_m, ws_l;

  logic [31:0] fifo_q[$];
  beat_t       exp_m[$], exp_l[$];
  logic [15:0] exp_words;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_count = 0;
  int          hs_count = 0;
  int          pat = 0;

  fifo_word_unpacker_if #(.WORD_W(32), .BYTE_W(8)) bus_m ();
  fifo_word_unpacker_if #(.WORD_W(32), .BYTE_W(8)) bus_l ();

  assign bus_m.tx_ready = ready;
  assign bus_l.tx_ready = ready;

  fifo_word_unpacker #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b0), .CNT_W(16)) dut_m (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bus(bus_m), .busy_o(busy_m), .words_sent_o(ws_m)
  );

  fifo_word_unpacker #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b1), .CNT_W(16)) dut_l (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bus(bus_l), .busy_o(busy_l), .words_sent_o(ws_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: registered dataOut, pops when EN and RD are sampled high.
  initial begin
    logic [31:0] w;
    beat_t       b;
    bus_m.fifo_empty = 1'b1;
    bus_l.fifo_empty = 1'b1;
    bus_m.fifo_data  = '0;
    bus_l.fifo_data  = '0;
    forever begin
      @(posedge clk);
      if (en && bus_m.fifo_rd) rd_count++;
      if (en && bus_m.fifo_rd && fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        bus_m.fifo_data <= w;
        bus_l.fifo_data <= w;
        for (int k = 0; k < 4; k++) begin
          b.last = (k == 3);
          b.data = 8'(w >> (8 * (3 - k)));
          exp_m.push_back(b);
          b.data = 8'(w >> (8 * k));
          exp_l.push_back(b);
        end
      end
      bus_m.fifo_empty <= (fifo_q.size() == 0);
      bus_l.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor / scoreboard.
  logic       prev_valid = 1'b0;
  logic       prev_fire  = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic       fire;
  beat_t      e;

  always @(negedge clk) begin
    if (rst) begin
      exp_m.delete();
      exp_l.delete();
      exp_words  = '0;
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      check("words_sent", ws_m, exp_words);
      check("words_sent_lsb", ws_l, exp_words);
      check("rd_when_empty", bus_m.fifo_rd & bus_m.fifo_empty, 0);
      check("rd_when_disabled", bus_m.fifo_rd & ~en, 0);
      check("lsb_rd_align", bus_l.fifo_rd, bus_m.fifo_rd);
      if (prev_valid && !prev_fire) begin
        check("hold_valid", bus_m.tx_valid, 1);
        check("hold_data", bus_m.tx_data, prev_data);
        check("hold_last", bus_m.tx_last, prev_last);
      end
      fire = bus_m.tx_valid & ready & en;
      if (fire) begin
        hs_count++;
        if (exp_m.size() == 0) check("unexpected_beat", bus_m.tx_data, {56'h0, 8'hXX});
        else begin
          e = exp_m.pop_front();
          check("beat_data", bus_m.tx_data, e.data);
          check("beat_last", bus_m.tx_last, e.last);
          if (e.last) exp_words = exp_words + 16'd1;
        end
        check("lsb_valid", bus_l.tx_valid, 1);
        if (exp_l.size() == 0) check("unexpected_beat_lsb", bus_l.tx_data, {56'h0, 8'hXX});
        else begin
          e = exp_l.pop_front();
          check("lsb_beat_data", bus_l.tx_data, e.data);
          check("lsb_beat_last", bus_l.tx_last, e.last);
        end
      end
      prev_valid = bus_m.tx_valid;
      prev_data  = bus_m.tx_data;
      prev_last  = bus_m.tx_last;
      prev_fire  = fire;
    end
  end

  // Advance one cycle and drive inputs #1 after the edge.
  // mode 0: ready=1; 1: ready pattern 1,0,0; 2: random ready and enable.
  task automatic tick(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0: ready = 1'b1;
      1: begin ready = (pat % 3 == 0); pat++; end
      default: begin
        ready = 1'($urandom_range(0, 1));
        en    = ($urandom_range(0, 7) != 0);
      end
    endcase
  endtask

  task automatic wait_idle(input int mode, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(mode);
      if (fifo_q.size() == 0 && bus_m.fifo_empty && !busy_m && !bus_m.tx_valid) done = 1'b1;
    end
    check("idle_reached", done, 1);
    en    = 1'b1;
    ready = 1'b1;
  endtask

  task automatic wait_empty_fall();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (!bus_m.fifo_empty) seen = 1'b1;
    end
    check("empty_fall", seen, 1);
  endtask

  initial begin
    int          first_rd, first_v, last_v, vcount, rd0, base;
    logic [31:0] w1, w2;
    rst   = 1'b1;
    en    = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus_m.tx_valid, 0);
    check("rst_data", bus_m.tx_data, 0);
    check("rst_last", bus_m.tx_last, 0);
    check("rst_rd", bus_m.fifo_rd, 0);
    check("rst_busy", busy_m, 0);
    check("rst_words", ws_m, 0);
    rst = 1'b0;

    // Single word, latency and consecutive beats.
    ready = 1'b1;
    fifo_q.push_back(32'hA1B2C3D4);
    wait_empty_fall();
    first_rd = -1; first_v = -1; vcount = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(0);
      if (bus_m.fifo_rd && first_rd < 0) first_rd = i;
      if (bus_m.tx_valid) begin
        if (first_v < 0) first_v = i;
        vcount++;
      end
    end
    check("t1_rd_latency", first_rd, 1);
    check("t1_valid_latency", first_v, 3);
    check("t1_valid_cycles", vcount, 4);
    check("t1_rd_pulses", rd_count, 1);
    wait_idle(0, 50);
    check("t1_words", ws_m, 1);

    // Back-pressure with ready 1,0,0,...
    rd0 = rd_count;
    pat = 0;
    fifo_q.push_back(32'hA1B2C3D4);
    wait_idle(1, 200);
    check("t2_rd_pulses", rd_count - rd0, 1);
    check("t2_words", ws_m, 2);

    // Back-to-back words: 12 beats, 2-cycle bubbles.
    rd0 = rd_count;
    fifo_q.push_back(32'h00000001);
    fifo_q.push_back(32'h11223344);
    fifo_q.push_back(32'hFFFFFFFF);
    wait_empty_fall();
    first_v = -1; last_v = -1; vcount = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(0);
      if (bus_m.tx_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        vcount++;
      end
    end
    check("t3_valid_cycles", vcount, 12);
    check("t3_span", last_v - first_v + 1, 16);
    check("t3_rd_pulses", rd_count - rd0, 3);
    wait_idle(0, 50);
    check("t3_busy", busy_m, 0);
    check("t3_words", ws_m, 5);

    // Enable gating after two beats.
    rd0  = rd_count;
    base = hs_count;
    fifo_q.push_back(32'hA1B2C3D4);
    for (int i = 0; i < 50 && hs_count < base + 2; i++) tick(0);
    check("t4_two_beats", hs_count - base, 2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", bus_m.tx_valid, 1);
      check("t4_hold_data", bus_m.tx_data, 8'hC3);
      check("t4_no_rd", bus_m.fifo_rd, 0);
    end
    check("t4_beats_during_gate", hs_count - base, 2);
    en = 1'b1;
    wait_idle(0, 50);
    check("t4_rd_pulses", rd_count - rd0, 1);
    check("t4_words", ws_m, 6);

    // Reset while the first beat of a word is presented.
    w1 = $urandom;
    w2 = $urandom;
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    for (int i = 0; i < 20 && !bus_m.tx_valid; i++) tick(0);
    check("t5_in_send", bus_m.tx_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid", bus_m.tx_valid, 0);
    check("t5_busy", busy_m, 0);
    check("t5_words", ws_m, 0);
    rst = 1'b0;
    wait_idle(0, 50);
    check("t5_drain_words", ws_m, 1);

    // Randomized traffic with random ready and enable.
    for (int i = 0; i < 24; i++) begin
      fifo_q.push_back($urandom);
      repeat ($urandom_range(0, 6)) tick(2);
    end
    wait_idle(2, 3000);
    check("t6_words", ws_m, 25);
    check("t6_queue_empty", exp_m.size() + exp_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
